// File: rtl/fir_out_stage.sv
// FIR post-processing: decimation, saturating shift gain, FWFT output FIFO.
// Sticky overflow/saturation flags; consumer drains via valid/ready.
module fir_out_stage #(
    parameter int DEPTH = 8,
    parameter int LW    = $clog2(DEPTH) + 1
) (
    input  logic          clk2,
    input  logic          rstn,
    input  logic          valid_in,
    input  logic [15:0]   din,
    input  logic [5:0]    decim,
    input  logic [2:0]    shift,
    input  logic          clr_flags,
    input  logic          m_ready,
    output logic          m_valid,
    output logic [15:0]   m_data,
    output logic [LW-1:0] level,
    output logic          overflow,
    output logic          sat
);
    localparam int AW = $clog2(DEPTH);

    logic [5:0]    dcnt_q, dcnt_d;
    logic          s_valid_q, s_valid_d;
    logic [15:0]   s_data_q, s_data_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [LW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;
    logic          sat_q, sat_d;
    logic [15:0]   mem_q [DEPTH];

    logic               keep;
    logic [6:0]         dinc;
    logic [6:0]         dmax;
    logic signed [22:0] y;
    logic [15:0]        yclip;
    logic               clip;
    logic               rd;
    logic               wr;

    always_comb begin
        keep = valid_in && (dcnt_q == 6'd0);
        dinc = {1'b0, dcnt_q} + 7'd1;
        dmax = (decim == 6'd0) ? 7'd1 : {1'b0, decim};
        dcnt_d = dcnt_q;
        if (valid_in) begin
            dcnt_d = (dinc >= dmax) ? 6'd0 : dinc[5:0];
        end
    end

    // 23 bits holds any 16-bit value shifted by up to 7.
    always_comb begin
        y = $signed({{7{din[15]}}, din}) <<< shift;
        clip = 1'b0;
        yclip = y[15:0];
        if (y > 23'sd32767) begin
            yclip = 16'h7FFF;
            clip = 1'b1;
        end else if (y < -23'sd32768) begin
            yclip = 16'h8000;
            clip = 1'b1;
        end
    end

    always_comb begin
        s_valid_d = keep;
        s_data_d  = keep ? yclip : s_data_q;
        rd = (count_q != '0) && m_ready;
        wr = s_valid_q && ((count_q < LW'(DEPTH)) || rd);
        wptr_d = wr ? wptr_q + AW'(1) : wptr_q;
        rptr_d = rd ? rptr_q + AW'(1) : rptr_q;
        count_d = count_q;
        if (wr && !rd) begin
            count_d = count_q + LW'(1);
        end else if (rd && !wr) begin
            count_d = count_q - LW'(1);
        end
        // A set in the same cycle as a clear takes priority.
        ovf_d = (s_valid_q && !wr) || (ovf_q && !clr_flags);
        sat_d = (keep && clip) || (sat_q && !clr_flags);
    end

    always_ff @(posedge clk2 or negedge rstn) begin
        if (!rstn) begin
            dcnt_q    <= '0;
            s_valid_q <= 1'b0;
            s_data_q  <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            sat_q     <= 1'b0;
        end else begin
            dcnt_q    <= dcnt_d;
            s_valid_q <= s_valid_d;
            s_data_q  <= s_data_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            sat_q     <= sat_d;
        end
    end

    always_ff @(posedge clk2) begin
        if (wr) begin
            mem_q[wptr_q] <= s_data_q;
        end
    end

    // Gate the head so stale storage never shows while empty.
    assign m_valid  = (count_q != '0);
    assign m_data   = m_valid ? mem_q[rptr_q] : 16'h0000;
    assign level    = count_q;
    assign overflow = ovf_q;
    assign sat      = sat_q;
endmodule

// File: tb/tb_fir_out_stage.sv
// Bench for fir_out_stage: directed vectors, scoreboard queue with
// an independent output monitor.
module tb_fir_out_stage;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk2 = 1'b0;
    logic          rstn;
    logic          valid_in;
    logic [15:0]   din;
    logic [5:0]    decim;
    logic [2:0]    shift;
    logic          clr_flags;
    logic          m_ready;
    logic          m_valid;
    logic [15:0]   m_data;
    logic [LW-1:0] level;
    logic          overflow;
    logic          sat;

    int checks   = 0;
    int failures = 0;
    logic [15:0] expq[$];

    fir_out_stage #(.DEPTH(DEPTH), .LW(LW)) dut (
        .clk2(clk2), .rstn(rstn), .valid_in(valid_in), .din(din),
        .decim(decim), .shift(shift), .clr_flags(clr_flags),
        .m_ready(m_ready), .m_valid(m_valid), .m_data(m_data),
        .level(level), .overflow(overflow), .sat(sat)
    );

    always #5 clk2 = ~clk2;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk2) begin
        if (rstn && m_valid && m_ready) begin
            if (expq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL pop: unexpected output %0h, none expected",
                         m_data);
            end else begin
                chk("pop_data", int'(m_data), int'(expq.pop_front()));
            end
        end
    end

    task automatic cyc();
        @(posedge clk2);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic strobe(input logic [15:0] d, input bit push,
                          input logic [15:0] e);
        valid_in = 1'b1;
        din = d;
        if (push) expq.push_back(e);
        cyc();
        valid_in = 1'b0;
    endtask

    task automatic at_neg();
        @(negedge clk2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1'b0; valid_in = 1'b0; din = '0; decim = 6'd1;
        shift = 3'd0; clr_flags = 1'b0; m_ready = 1'b0;
        idle(2);
        at_neg();
        chk("rst_m_valid", int'(m_valid), 0);
        chk("rst_m_data", int'(m_data), 0);
        chk("rst_level", int'(level), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_sat", int'(sat), 0);
        cyc();
        rstn = 1'b1;
        idle(1);

        // single sample, 2-edge latency
        strobe(16'h1234, 1, 16'h1234);
        cyc();
        at_neg();
        chk("single_m_valid", int'(m_valid), 1);
        chk("single_m_data", int'(m_data), 16'h1234);
        chk("single_level", int'(level), 1);
        cyc();
        m_ready = 1'b1;
        cyc();
        m_ready = 1'b0;
        at_neg();
        chk("single_drained", int'(m_valid), 0);

        // decimation by 4
        cyc();
        decim = 6'd4;
        for (int i = 0; i < 12; i++)
            strobe(16'(i), (i % 4) == 0, 16'(i));
        idle(2);
        at_neg();
        chk("decim4_level", int'(level), 3);
        cyc();
        m_ready = 1'b1;
        idle(4);
        at_neg();
        chk("decim4_drained", int'(m_valid), 0);
        cyc();
        decim = 6'd0;
        strobe(16'h0011, 1, 16'h0011);
        strobe(16'h0022, 1, 16'h0022);
        strobe(16'h0033, 1, 16'h0033);
        idle(3);

        // saturation
        decim = 6'd1;
        shift = 3'd3;
        strobe(16'h1000, 1, 16'h7FFF);
        at_neg();
        chk("sat_pos_flag", int'(sat), 1);
        cyc();
        strobe(16'hF000, 1, 16'h8000);
        strobe(16'h0FFF, 1, 16'h7FF8);
        shift = 3'd7;
        strobe(16'hFFFF, 1, 16'hFF80);
        shift = 3'd0;
        strobe(16'h8000, 1, 16'h8000);
        at_neg();
        chk("sat_held", int'(sat), 1);
        cyc();
        clr_flags = 1'b1;
        cyc();
        clr_flags = 1'b0;
        at_neg();
        chk("sat_cleared", int'(sat), 0);
        cyc();
        shift = 3'd3;
        clr_flags = 1'b1;
        strobe(16'h7000, 1, 16'h7FFF);
        clr_flags = 1'b0;
        at_neg();
        chk("sat_set_wins", int'(sat), 1);
        cyc();
        clr_flags = 1'b1;
        cyc();
        clr_flags = 1'b0;
        decim = 6'd2;
        strobe(16'h0001, 1, 16'h0008);
        strobe(16'h7000, 0, 16'h0000);
        at_neg();
        chk("sat_dropped_no_set", int'(sat), 0);
        cyc();
        decim = 6'd1;
        shift = 3'd0;
        idle(4);
        at_neg();
        chk("sat_drained", int'(m_valid), 0);

        // fill and overflow
        cyc();
        m_ready = 1'b0;
        for (int i = 1; i <= 9; i++)
            strobe(16'(i), i <= 8, 16'(i));
        idle(2);
        at_neg();
        chk("full_level", int'(level), 8);
        chk("full_overflow", int'(overflow), 1);
        chk("full_head", int'(m_data), 1);
        cyc();
        clr_flags = 1'b1;
        cyc();
        clr_flags = 1'b0;
        at_neg();
        chk("ovf_cleared", int'(overflow), 0);

        // write and read together at full
        cyc();
        strobe(16'h000A, 1, 16'h000A);
        m_ready = 1'b1;
        cyc();
        m_ready = 1'b0;
        at_neg();
        chk("rw_full_level", int'(level), 8);
        chk("rw_full_overflow", int'(overflow), 0);
        cyc();
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++)
            strobe(16'(100 + i), 1, 16'(100 + i));
        idle(12);
        at_neg();
        chk("wrap_level", int'(level), 0);
        chk("wrap_overflow", int'(overflow), 0);
        chk("wrap_queue_empty", expq.size(), 0);

        // asynchronous reset mid-operation
        cyc();
        m_ready = 1'b0;
        for (int i = 1; i <= 6; i++)
            strobe(16'(200 + i), 1, 16'(200 + i));
        chk("pre_rst_level", int'(level), 5);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_m_valid", int'(m_valid), 0);
        chk("arst_m_data", int'(m_data), 0);
        chk("arst_level", int'(level), 0);
        chk("arst_overflow", int'(overflow), 0);
        expq.delete();
        idle(2);
        rstn = 1'b1;
        idle(4);
        at_neg();
        chk("post_rst_m_valid", int'(m_valid), 0);
        chk("post_rst_level", int'(level), 0);
        cyc();
        m_ready = 1'b1;
        idle(4);
        m_ready = 1'b0;
        idle(1);
        chk("final_queue_empty", expq.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
